// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
// ---------------------------------------------------------------------------
// Write-side controller for the integer register file. It merges the
// in-order pipeline writeback (source A) with long-latency results (source B,
// e.g. div/mul, load-miss) onto the single register-file write port. B results
// wait in a small in-order FIFO. A per-register pending scoreboard tells the
// issue stage which registers still await a long-latency result.
//
// Optional feature: define WB_STARVE_GUARD_EN to enable the starvation guard.
// After STARVE_MAX consecutive A wins with B waiting, the FIFO head is forced
// onto the port for one cycle and A is stalled.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   a_valid/a_addr/a_data     pipeline writeback request (r0 ignored)
//   a_stall                   A held this cycle (guard build only, else 0)
//   b_valid/b_ready/b_addr/b_data  long-latency result handshake into FIFO
//   mark_en/mark_addr         long-latency op issued: set pending bit
//   q1_addr/q1_busy, q2_addr/q2_busy  combinational scoreboard queries
//   rw_en/rw_addr/rw_data     registered register-file write port
//   fifo_count                current FIFO occupancy
// ---------------------------------------------------------------------------
module regfile_wb_ctrl #(
   parameter int REG_WIDTH  = 5,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          a_valid,
   input  logic [REG_WIDTH-1:0]          a_addr,
   input  logic [DATA_WIDTH-1:0]         a_data,
   output logic                          a_stall,
   input  logic                          b_valid,
   output logic                          b_ready,
   input  logic [REG_WIDTH-1:0]          b_addr,
   input  logic [DATA_WIDTH-1:0]         b_data,
   input  logic                          mark_en,
   input  logic [REG_WIDTH-1:0]          mark_addr,
   input  logic [REG_WIDTH-1:0]          q1_addr,
   output logic                          q1_busy,
   input  logic [REG_WIDTH-1:0]          q2_addr,
   output logic                          q2_busy,
   output logic                          rw_en,
   output logic [REG_WIDTH-1:0]          rw_addr,
   output logic [DATA_WIDTH-1:0]         rw_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int REG_NUM = 1 << REG_WIDTH;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;

   // Elaboration-time sanity check of the configuration.
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_MAX < 1) begin : g_param_check
      $error("regfile_wb_ctrl: FIFO_DEPTH must be a power of 2 >= 2 and STARVE_MAX >= 1");
   end

   logic [REG_WIDTH-1:0]  fifo_addr [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [REG_NUM-1:0]    pending;

   logic                  a_req;
   logic                  fifo_ne;
   logic                  push;
   logic                  pop;
   logic                  a_win;
   logic                  guard_active;
   logic [REG_WIDTH-1:0]  head_addr;
   logic [DATA_WIDTH-1:0] head_data;

   assign a_req     = a_valid && (a_addr != '0);
   assign fifo_ne   = (fifo_count != '0);
   assign head_addr = fifo_addr[rd_ptr];
   assign head_data = fifo_data[rd_ptr];

   // No pass-through: a full FIFO refuses input even in a cycle it pops.
   assign b_ready = !rst && (fifo_count < CNT_W'(FIFO_DEPTH));
   // Writes to r0 are accepted on the handshake but never stored.
   assign push    = b_valid && b_ready && (b_addr != '0);

   assign a_win   = a_req && !guard_active;
   assign pop     = !a_win && fifo_ne;

`ifdef WB_STARVE_GUARD_EN
   localparam int SC_W = $clog2(STARVE_MAX + 1);
   logic [SC_W-1:0] starve_cnt;

   // Counts A wins that happened while B was waiting; saturates at the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (pop) begin
         starve_cnt <= '0;
      end else if (a_win && fifo_ne && (starve_cnt != SC_W'(STARVE_MAX))) begin
         starve_cnt <= starve_cnt + SC_W'(1);
      end
   end

   assign guard_active = fifo_ne && (starve_cnt == SC_W'(STARVE_MAX));
`else
   assign guard_active = 1'b0;
`endif

   assign a_stall = !rst && guard_active;

   // NOTE: the FIFO storage carries no reset; only pointers and count define
   // validity, so stale entries are never observable and the array maps to
   // plain RAM/flops without reset muxes.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= b_addr;
         fifo_data[wr_ptr] <= b_data;
      end
   end

   // NOTE: all state updates use non-blocking assignments so every process
   // sees pre-edge values, independent of evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Write port: A first (unless guarded), then FIFO head, else idle with
   // address/data held.
   always_ff @(posedge clk) begin
      if (rst) begin
         rw_en   <= 1'b0;
         rw_addr <= '0;
         rw_data <= '0;
      end else if (a_win) begin
         rw_en   <= 1'b1;
         rw_addr <= a_addr;
         rw_data <= a_data;
      end else if (pop) begin
         rw_en   <= 1'b1;
         rw_addr <= head_addr;
         rw_data <= head_data;
      end else begin
         rw_en   <= 1'b0;
      end
   end

   // Scoreboard: the set is written last so a same-cycle set of the popped
   // register wins over the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else begin
         if (pop) pending[head_addr] <= 1'b0;
         if (mark_en && (mark_addr != '0)) pending[mark_addr] <= 1'b1;
      end
   end

   // The rw_* term covers the cycle between leaving this block and the
   // register-file commit.
   assign q1_busy = (q1_addr != '0) && (pending[q1_addr] || (rw_en && (rw_addr == q1_addr)));
   assign q2_busy = (q2_addr != '0) && (pending[q2_addr] || (rw_en && (rw_addr == q2_addr)));

endmodule
